// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder arbiter slice.
// Tag entries follow each operation through the adder latency.
package adder_arb_pkg;

    localparam int BW_DEF   = 32;
    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin arbiter.
// Grants the first request at or above ptr, wrapping modulo N.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int N   = NREQ_DEF,
    localparam int IDW = id_w(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder between NREQ requesters.
// Requester ids ride a tag pipeline matched to the adder latency.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int BW   = BW_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int LAT  = 1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*BW-1:0] req_a,
    input  logic [NREQ*BW-1:0] req_b,
    input  logic [NREQ-1:0]  req_cin,
    output logic [BW-1:0]    add_a,
    output logic [BW-1:0]    add_b,
    output logic             add_cin,
    input  logic [BW-1:0]    add_sum,
    input  logic             add_cout,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [BW-1:0]    rsp_sum,
    output logic             rsp_cout,
    output logic             busy,
    output logic [15:0]      ops_done
);

    localparam int IDW = id_w(NREQ);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } stage_t;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic           hs;
    stage_t [LAT:0] tag;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // A grant is only ever issued to a valid requester.
    assign req_ready = gnt;
    assign hs        = |gnt;
    assign ptr_nxt   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rr_ptr  <= '0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (hs) begin
            rr_ptr  <= ptr_nxt;
            add_a   <= req_a[int'(gnt_id)*BW +: BW];
            add_b   <= req_b[int'(gnt_id)*BW +: BW];
            add_cin <= req_cin[gnt_id];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tag <= '0;
        end else begin
            tag[0].valid <= hs;
            tag[0].id    <= gnt_id;
            for (int i = 1; i <= LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            ops_done  <= '0;
        end else begin
            rsp_valid <= '0;
            if (tag[LAT].valid) begin
                rsp_valid <= NREQ'(1) << tag[LAT].id;
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
            end
            if (|rsp_valid) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int i = 0; i <= LAT; i++) begin
            busy = busy | tag[i].valid;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter at LAT 1, plus LAT 0 and 3 copies
// sharing the same stimulus for the latency sweep.
module tb_adder_arbiter;

    localparam int BW = 32;
    localparam int NR = 4;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*BW-1:0] req_a = '0;
    logic [NR*BW-1:0] req_b = '0;
    logic [NR-1:0] req_cin = '0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // LAT 1 instance
    logic [NR-1:0] rdy1, rv1;
    logic [BW-1:0] aa1, ab1, as1, rs1;
    logic ac1, aco1, rc1, busy1;
    logic [15:0] ops1;
    logic [BW:0] r1;

    adder_arbiter #(.BW(BW), .NREQ(NR), .LAT(1)) dut1 (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(rdy1),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(aa1), .add_b(ab1), .add_cin(ac1),
        .add_sum(as1), .add_cout(aco1),
        .rsp_valid(rv1), .rsp_sum(rs1), .rsp_cout(rc1),
        .busy(busy1), .ops_done(ops1)
    );

    always @(posedge CLK) r1 <= {1'b0, aa1} + {1'b0, ab1} + 33'(ac1);
    assign as1  = r1[BW-1:0];
    assign aco1 = r1[BW];

    // LAT 0 instance
    logic [NR-1:0] rdy0, rv0;
    logic [BW-1:0] aa0, ab0, as0, rs0;
    logic ac0, aco0, rc0, busy0;
    logic [15:0] ops0;
    logic [BW:0] r0;

    adder_arbiter #(.BW(BW), .NREQ(NR), .LAT(0)) dut0 (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(rdy0),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(aa0), .add_b(ab0), .add_cin(ac0),
        .add_sum(as0), .add_cout(aco0),
        .rsp_valid(rv0), .rsp_sum(rs0), .rsp_cout(rc0),
        .busy(busy0), .ops_done(ops0)
    );

    assign r0   = {1'b0, aa0} + {1'b0, ab0} + 33'(ac0);
    assign as0  = r0[BW-1:0];
    assign aco0 = r0[BW];

    // LAT 3 instance
    logic [NR-1:0] rdy3, rv3;
    logic [BW-1:0] aa3, ab3, as3, rs3;
    logic ac3, aco3, rc3, busy3;
    logic [15:0] ops3;
    logic [BW:0] p3a, p3b, p3c;

    adder_arbiter #(.BW(BW), .NREQ(NR), .LAT(3)) dut3 (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(rdy3),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(aa3), .add_b(ab3), .add_cin(ac3),
        .add_sum(as3), .add_cout(aco3),
        .rsp_valid(rv3), .rsp_sum(rs3), .rsp_cout(rc3),
        .busy(busy3), .ops_done(ops3)
    );

    always @(posedge CLK) begin
        p3a <= {1'b0, aa3} + {1'b0, ab3} + 33'(ac3);
        p3b <= p3a;
        p3c <= p3b;
    end
    assign as3  = p3c[BW-1:0];
    assign aco3 = p3c[BW];

    function automatic logic [BW:0] model(input int i);
        return 33'(i*16 + 1) + 33'(i + 2) + 33'(i % 2);
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [BW-1:0] a,
                           input logic [BW-1:0] b, input logic c);
        req_a[i*BW +: BW] = a;
        req_b[i*BW +: BW] = b;
        req_cin[i] = c;
    endtask

    task automatic set_all;
        for (int i = 0; i < NR; i++)
            set_req(i, 32'(i*16 + 1), 32'(i + 2), 1'(i % 2));
    endtask

    task automatic do_reset;
        req_valid = '0;
        RESETn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
    endtask

    task automatic test_reset;
        req_valid = '0;
        set_all();
        RESETn = 1'b0;
        @(negedge CLK);
        checks++;
        if ({rdy1, aa1, ab1, ac1} !== '0) begin
            failures++;
            $display("FAIL reset_issue got=%h/%h/%h/%b exp=0", rdy1, aa1, ab1, ac1);
        end
        checks++;
        if ({rv1, rs1, rc1, busy1, ops1} !== '0) begin
            failures++;
            $display("FAIL reset_rsp got rv=%b sum=%h c=%b busy=%b ops=%0d exp=0",
                     rv1, rs1, rc1, busy1, ops1);
        end
        step();
        RESETn = 1'b1;
    endtask

    task automatic test_single;
        int lat = 0;
        do_reset();
        set_req(0, 32'd5, 32'd7, 1'b1);
        req_valid = 4'b0001;
        @(negedge CLK);
        checks++;
        if (rdy1 !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got=%b exp=0001", rdy1);
        end
        step();
        req_valid = '0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge CLK);
            if (rv1 !== '0) begin
                lat = c;
                checks++;
                if (rv1 !== 4'b0001 || rs1 !== 32'd13 || rc1 !== 1'b0) begin
                    failures++;
                    $display("FAIL single_rsp got rv=%b sum=%0d c=%b exp 0001/13/0",
                             rv1, rs1, rc1);
                end
            end
            step();
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=3", lat);
        end
        @(negedge CLK);
        checks++;
        if (ops1 !== 16'd1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL single_ops got ops=%0d busy=%b exp 1/0", ops1, busy1);
        end
        step();
    endtask

    task automatic test_overflow;
        int lat = 0;
        set_req(2, 32'hFFFF_FFFF, 32'd1, 1'b0);
        req_valid = 4'b0100;
        @(negedge CLK);
        checks++;
        if (rdy1 !== 4'b0100) begin
            failures++;
            $display("FAIL ovf_grant got=%b exp=0100", rdy1);
        end
        step();
        req_valid = '0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge CLK);
            if (rv1 !== '0) begin
                lat = c;
                checks++;
                if (rv1 !== 4'b0100 || rs1 !== 32'd0 || rc1 !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_rsp got rv=%b sum=%h c=%b exp 0100/0/1",
                             rv1, rs1, rc1);
                end
            end
            step();
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL ovf_latency got=%0d exp=3", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] e;
        do_reset();
        set_all();
        for (int c = 0; c <= 10; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            @(negedge CLK);
            if (c < 8) begin
                e = 4'b0001 << (c % 4);
                checks++;
                if (rdy1 !== e) begin
                    failures++;
                    $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, rdy1, e);
                end
            end
            if (c >= 3) begin
                e = 4'b0001 << ((c - 3) % 4);
                checks++;
                if (rv1 !== e || {rc1, rs1} !== model((c - 3) % 4)) begin
                    failures++;
                    $display("FAIL b2b_rsp c=%0d got %b/%h exp %b/%h",
                             c, rv1, {rc1, rs1}, e, model((c - 3) % 4));
                end
            end
            if (c >= 1) begin
                checks++;
                if (busy1 !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_busy c=%0d got=%b exp=1", c, busy1);
                end
            end
            step();
        end
        @(negedge CLK);
        checks++;
        if (ops1 !== 16'd8) begin
            failures++;
            $display("FAIL b2b_ops got=%0d exp=8", ops1);
        end
        step();
    endtask

    task automatic test_fairness;
        logic [3:0] vs [4] = '{4'b1010, 4'b1010, 4'b0010, 4'b0010};
        logic [3:0] gs [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b0010};
        int ids [4] = '{1, 3, 1, 1};
        do_reset();
        set_all();
        for (int c = 0; c <= 6; c++) begin
            req_valid = (c < 4) ? vs[c] : 4'h0;
            @(negedge CLK);
            if (c < 4) begin
                checks++;
                if (rdy1 !== gs[c]) begin
                    failures++;
                    $display("FAIL fair_grant c=%0d got=%b exp=%b", c, rdy1, gs[c]);
                end
            end
            if (c >= 3) begin
                checks++;
                if (rv1 !== gs[c-3] || {rc1, rs1} !== model(ids[c-3])) begin
                    failures++;
                    $display("FAIL fair_rsp c=%0d got %b/%h exp %b/%h",
                             c, rv1, {rc1, rs1}, gs[c-3], model(ids[c-3]));
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid;
        set_req(0, 32'd9, 32'd9, 1'b0);
        req_valid = 4'b0001;
        @(negedge CLK);
        checks++;
        if (rdy1 !== 4'b0001) begin
            failures++;
            $display("FAIL mid_grant got=%b exp=0001", rdy1);
        end
        step();
        req_valid = '0;
        RESETn = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (rv1 !== '0 || ops1 !== 16'd0 || busy1 !== 1'b0) begin
                failures++;
                $display("FAIL mid_drop c=%0d got rv=%b ops=%0d busy=%b exp 0/0/0",
                         c, rv1, ops1, busy1);
            end
            step();
        end
        RESETn = 1'b1;
        req_valid = 4'hF;
        @(negedge CLK);
        checks++;
        if (rdy1 !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr got=%b exp=0001", rdy1);
        end
        step();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            checks++;
            if (c < 3 && rv1 !== '0) begin
                failures++;
                $display("FAIL mid_norsp c=%0d got=%b exp=0", c, rv1);
            end else if (c == 3 && (rv1 !== 4'b0001 || rs1 !== 32'd18 || ops1 !== 16'd0)) begin
                failures++;
                $display("FAIL mid_rsp got %b/%0d ops=%0d exp 0001/18/0", rv1, rs1, ops1);
            end
            step();
        end
        @(negedge CLK);
        checks++;
        if (ops1 !== 16'd1) begin
            failures++;
            $display("FAIL mid_ops got=%0d exp=1", ops1);
        end
        step();
    endtask

    task automatic test_latency;
        int l0 = 0, l1 = 0, l3 = 0;
        logic [BW:0] s0 = '0, s1 = '0, s3 = '0;
        do_reset();
        set_req(1, 32'h1234, 32'h4321, 1'b1);
        req_valid = 4'b0010;
        @(negedge CLK);
        checks++;
        if ({rdy0, rdy1, rdy3} !== {3{4'b0010}}) begin
            failures++;
            $display("FAIL lat_grant got=%b/%b/%b exp 0010", rdy0, rdy1, rdy3);
        end
        step();
        req_valid = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (l0 == 0 && rv0 !== '0) begin l0 = c; s0 = {rc0, rs0}; end
            if (l1 == 0 && rv1 !== '0) begin l1 = c; s1 = {rc1, rs1}; end
            if (l3 == 0 && rv3 !== '0) begin l3 = c; s3 = {rc3, rs3}; end
            step();
        end
        checks++;
        if (l0 != 2 || l1 != 3 || l3 != 5) begin
            failures++;
            $display("FAIL lat_cycles got=%0d/%0d/%0d exp 2/3/5", l0, l1, l3);
        end
        checks++;
        if (s0 !== 33'h5556 || s1 !== 33'h5556 || s3 !== 33'h5556) begin
            failures++;
            $display("FAIL lat_sum got=%h/%h/%h exp 5556", s0, s1, s3);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        set_all();
        for (int c = 0; c <= 65542; c++) begin
            req_valid = (c < 65536) ? 4'hF : 4'h0;
            if (c == 65538 || c == 65539 || c == 65542) begin
                @(negedge CLK);
                checks++;
                if (c == 65538 && ops1 !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL wrap_max got=%h exp=ffff", ops1);
                end else if (c == 65539 && ops1 !== 16'h0000) begin
                    failures++;
                    $display("FAIL wrap_zero got=%h exp=0000", ops1);
                end else if (c == 65542 && (busy1 !== 1'b0 || ops1 !== 16'h0000)) begin
                    failures++;
                    $display("FAIL wrap_idle got busy=%b ops=%h exp 0/0000", busy1, ops1);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_fairness();
        test_reset_mid();
        test_latency();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
